// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and frame constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Per-bit tick generator: free-running 0..CLKS_PER_BIT-1 counter.
// tick pulses for one cycle on the last count; clear restarts the bit period.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (8E1/8O1 when UART_TX_PARITY_EN is defined).
// All outputs are registered from the next state, so tx tracks the FSM with no input-to-output path.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned BW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic                      tx_q, tx_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      accept;
    logic                      tick;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign accept = tx_valid && ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    bit_d    = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state being entered so the registered line changes on the bit boundary itself.
    always_comb begin
        tx_d    = UART_IDLE_LEVEL;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4; covers UART_TX_PARITY_EN when defined.
// Two instances share inputs: even parity (dut_e) and odd parity (dut_o).
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int L = NB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_e, ready_e, busy_e;
    logic       tx_o, ready_o, busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_e), .tx(tx_e), .busy(busy_e)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_o), .tx(tx_o), .busy(busy_o)
    );

    // Reference frame: start 0, data LSB first, optional parity, stop 1.
    function automatic logic frame_bit(input logic [7:0] d, input int podd, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return logic'(($countones(d) + podd) % 2);
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_obs();
        @(posedge clk);
        #1;
    endtask

    // Caller has tx_valid=1 with tx_data=d in a cycle where tx_ready=1.
    task automatic run_frame(input logic [7:0] d, input bit hold, input logic [7:0] nxt);
        logic [7:0] dec_e = '0;
        logic [7:0] dec_o = '0;
        logic       par_e = 1'b0;
        logic       par_o = 1'b0;
        int         idx;
        tick_obs();
        for (int k = 1; k <= L + 1; k++) begin
            if (k <= L) begin
                idx = (k - 1) / CPB;
                chk("tx_e", tx_e, frame_bit(d, 0, idx));
                chk("tx_o", tx_o, frame_bit(d, 1, idx));
                chk("ready_busy", {ready_e, busy_e, ready_o, busy_o}, 8'b0101);
                if ((k - 1) % CPB == CPB / 2) begin
                    if (idx >= 1 && idx <= 8) begin
                        dec_e[idx-1] = tx_e;
                        dec_o[idx-1] = tx_o;
                    end
                    if (idx == 9) begin
                        par_e = tx_e;
                        par_o = tx_o;
                    end
                end
                if (hold) begin
                    tx_valid = 1'b1;
                    tx_data  = nxt;
                end else begin
                    tx_valid = 1'($urandom_range(0, 1));
                    tx_data  = 8'($urandom);
                end
                tick_obs();
            end else begin
                chk("end_tx", {tx_e, tx_o}, 8'b11);
                chk("end_ready_busy", {ready_e, busy_e, ready_o, busy_o}, 8'b1010);
                chk("decode_e", dec_e, d);
                chk("decode_o", dec_o, d);
`ifdef UART_TX_PARITY_EN
                chk("parity_e", par_e, 8'(($countones(d)) % 2));
                chk("parity_o", par_o, 8'(($countones(d) + 1) % 2));
                if (d == 8'h07) begin
                    chk("parity07_even", par_e, 8'd1);
                    chk("parity07_odd", par_o, 8'd0);
                end
`endif
                tx_valid = hold;
                if (hold) tx_data = nxt;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, n;
        bit         h;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        tick_obs();
        tick_obs();
        rst = 1'b0;
        chk("reset_tx", {tx_e, tx_o}, 8'b11);
        chk("reset_ready_busy", {ready_e, busy_e, ready_o, busy_o}, 8'b1010);

        for (int i = 0; i < 1000; i++) begin
            tx_data = 8'($urandom);
            tick_obs();
            chk("idle_tx_busy", {tx_e, busy_e}, 8'b10);
        end

        tx_valid = 1'b1; tx_data = 8'h55;
        run_frame(8'h55, 1'b0, 8'h00);

        tx_valid = 1'b1; tx_data = 8'h81;
        run_frame(8'h81, 1'b0, 8'h00);

        tx_valid = 1'b1; tx_data = 8'hA5;
        run_frame(8'hA5, 1'b1, 8'h3C);
        run_frame(8'h3C, 1'b0, 8'h00);

        tx_valid = 1'b1; tx_data = 8'h07;
        run_frame(8'h07, 1'b0, 8'h00);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            n = 8'($urandom);
            h = 1'($urandom_range(0, 1));
            tx_valid = 1'b1; tx_data = d;
            run_frame(d, h, n);
            if (h) run_frame(n, 1'b0, 8'h00);
        end

        // Abort 0xFF during data bit 3; a tx_valid during reset must be ignored.
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick_obs();
        tx_valid = 1'b0;
        repeat (4 * CPB + 1) tick_obs();
        chk("mid_frame_busy", {tx_e, busy_e}, 8'b11);
        rst = 1'b1; tx_valid = 1'b1;
        tick_obs();
        rst = 1'b0; tx_valid = 1'b0;
        chk("abort_tx", {tx_e, tx_o}, 8'b11);
        chk("abort_ready_busy", {ready_e, busy_e, ready_o, busy_o}, 8'b1010);
        for (int i = 0; i < 2 * L; i++) begin
            tick_obs();
            chk("post_abort_idle", {tx_e, busy_e, ready_e}, 8'b101);
        end

        tx_valid = 1'b1; tx_data = 8'h3C;
        run_frame(8'h3C, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
